// File: rtl/bin_to_xs3.sv
// bin_to_xs3: registered 4-bit binary to excess-3 converter with an accepted-sample counter.
// Define XS3_RANGE_CHECK_EN to flag accepted operands above 9; otherwise out_of_range is tied low.
module bin_to_xs3 #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [3:0]         a,
    output logic [4:0]         y,
    output logic               out_valid,
    output logic               out_of_range,
    output logic [COUNT_W-1:0] conv_count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y          <= '0;
            out_valid  <= 1'b0;
            conv_count <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y          <= {1'b0, a} + 5'd3;
                conv_count <= conv_count + 1'b1;
            end
        end
    end
`ifdef XS3_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_of_range <= 1'b0;
        else if (in_valid) out_of_range <= a > 4'd9;
    end
`else
    assign out_of_range = 1'b0;
`endif
endmodule

// File: tb/tb_bin_to_xs3.sv
// tb_bin_to_xs3: directed checks of bin_to_xs3 with hand-computed expected values.
module tb_bin_to_xs3;
`ifdef XS3_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [4:0] y;
    logic       out_valid;
    logic       out_of_range;
    logic [7:0] conv_count;
    int n_vec = 0;
    int n_err = 0;

    bin_to_xs3 #(.COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
        .y(y), .out_valid(out_valid), .out_of_range(out_of_range), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] av);
        in_valid = v;
        a = av;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_xs3(input string tag, input logic [3:0] av, input logic [7:0] cnt);
        check({tag, "_y"}, 32'(y), 32'(av) + 32'd3);
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
        check({tag, "_oor"}, 32'(out_of_range), 32'(RC && av > 4'd9));
        check({tag, "_cnt"}, 32'(conv_count), 32'(cnt));
    endtask

    initial begin
        logic [3:0] r;
        logic [7:0] held;
        #2;
        check("rst_y", 32'(y), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_oor", 32'(out_of_range), 32'd0);
        check("rst_cnt", 32'(conv_count), 32'd0);
        do_reset();
        step(1'b1, 4'd0);
        check_xs3("first", 4'd0, 8'd1);
        step(1'b1, 4'd9);
        check_xs3("nine", 4'd9, 8'd2);
        step(1'b1, 4'd15);
        check_xs3("fifteen", 4'd15, 8'd3);
        check("y18", 32'(y), 32'd18);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i));
            check_xs3("sweep", 4'(i), 8'(i + 1));
        end
        check("sweep_cnt", 32'(conv_count), 32'd16);
        for (int i = 0; i < 20; i++) begin
            r = 4'($urandom_range(0, 15));
            step(1'b1, r);
            check_xs3("rand", r, 8'(17 + i));
        end
        step(1'b1, 4'd5);
        held = conv_count;
        check("hold_y0", 32'(y), 32'd8);
        step(1'b0, 4'd12);
        check("hold_ov", 32'(out_valid), 32'd0);
        step(1'b0, 4'bxxxx);
        step(1'b0, 4'd1);
        check("hold_y", 32'(y), 32'd8);
        check("hold_oor", 32'(out_of_range), 32'd0);
        check("hold_cnt", 32'(conv_count), 32'(held));
        check("hold_ov2", 32'(out_valid), 32'd0);
        do_reset();
        for (int i = 0; i < 255; i++) step(1'b1, 4'(i % 16));
        check("cnt255", 32'(conv_count), 32'd255);
        step(1'b1, 4'd7);
        check("wrap_cnt", 32'(conv_count), 32'd0);
        check("wrap_y", 32'(y), 32'd10);
        in_valid = 1'b1;
        a = 4'd2;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y", 32'(y), 32'd0);
        check("async_ov", 32'(out_valid), 32'd0);
        check("async_oor", 32'(out_of_range), 32'd0);
        check("async_cnt", 32'(conv_count), 32'd0);
        @(posedge clk);
        #1;
        check("inrst_ov", 32'(out_valid), 32'd0);
        check("inrst_y", 32'(y), 32'd0);
        rst_n = 1'b1;
        step(1'b0, 4'd2);
        check("post_ov", 32'(out_valid), 32'd0);
        check("post_cnt", 32'(conv_count), 32'd0);
        step(1'b1, 4'd15);
        check_xs3("post15", 4'd15, 8'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bin_to_xs3.md
BIN_TO_XS3 -- requirements
Module: bin_to_xs3

Interface
REQ-001 Parameter: COUNT_W, default 8, width of the accepted-conversion counter.
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  qualifies a; sample taken only when high at a rising clk edge.
REQ-005 Port: a  input  4  unsigned binary operand, 0..15.
REQ-006 Port: y  output  5  registered excess-3 result, a + 3, range 3..18.
REQ-007 Port: out_valid  output  1  high for exactly the cycle after each accepted sample.
REQ-008 Port: out_of_range  output  1  registered flag; high when the accepted a exceeds 9 (not a BCD digit).
REQ-009 Port: conv_count  output  COUNT_W  number of accepted samples, modulo 2^COUNT_W.

Function
REQ-010 On a rising clk edge with in_valid=1, the block SHALL load y with a + 3, zero-extended to 5 bits, with no truncation.
REQ-011 The latency from an accepted sample to y and out_valid SHALL be exactly 1 clock; back-to-back samples SHALL be accepted every cycle with no stalls.
REQ-012 On a rising edge with in_valid=0, the block SHALL clear out_valid and hold y, out_of_range and conv_count unchanged.
REQ-013 out_of_range SHALL update only on accepted samples and follow the same 1-cycle latency as y.
REQ-014 conv_count SHALL increment by 1 per accepted sample and wrap from 2^COUNT_W-1 to 0 without any flag.
REQ-015 All outputs SHALL be driven directly from flops; the block SHALL have no combinational path from any input to any output.
REQ-016 The block SHALL use no state machine beyond the registers named in REQ-010 to REQ-014.
REQ-017 X or Z values on a while in_valid=0 SHALL NOT affect any output.

Reset
REQ-018 When rst_n is low, the block SHALL immediately, independent of clk, force y=0, out_valid=0, out_of_range=0 and conv_count=0.
REQ-019 While rst_n is low, the block SHALL ignore in_valid and a.
REQ-020 The first sample accepted after reset SHALL be the one presented at the first rising clk edge with rst_n high.
REQ-021 If reset asserts while a sample is in flight, that sample SHALL be discarded and out_valid SHALL NOT pulse for it.

Configuration
REQ-022 Macro XS3_RANGE_CHECK_EN: when defined, out_of_range SHALL behave per REQ-008 and REQ-013.
REQ-023 When XS3_RANGE_CHECK_EN is undefined, out_of_range SHALL be tied to constant 0, the comparison logic SHALL be omitted, and all other behaviour SHALL be unchanged.

Verification
REQ-024 Reset then in_valid=1, a=0 for one cycle -> next cycle y=3, out_valid=1, out_of_range=0, conv_count=1.
REQ-025 a=9 then a=15 on consecutive cycles -> y=12 with out_of_range=0, then y=18 with out_of_range=1 (macro defined), out_valid high both cycles.
REQ-026 Sweep a=0..15 with in_valid=1 -> each y equals a+3 one cycle later; conv_count=16; 20 random values checked against a+3.
REQ-027 Accept a=5, then hold in_valid=0 for 3 cycles while toggling a -> y stays 8, out_valid drops after 1 cycle, conv_count unchanged.
REQ-028 With COUNT_W=8, accept 256 samples -> conv_count wraps to 0; then assert rst_n=0 mid-stream between edges -> all outputs 0 immediately, no out_valid pulse for the discarded sample.
REQ-029 Build without XS3_RANGE_CHECK_EN, apply a=15 -> y=18, out_of_range=0.
